// File: rtl/alu_operand_loader.sv
// Operand/opcode sequencer for the 8-bit ALU: captures A, B and opcode
// from a shared switch bus on debounced load presses, then strobes do_op.
module alu_operand_loader #(
    parameter int               WIDTH    = 8,
    parameter int               SEL_W    = 4,
    parameter logic [SEL_W-1:0] UNARY_OP = 4'b1100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             load,
    input  logic             clear,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [SEL_W-1:0] select,
    output logic             do_op,
    output logic [1:0]       state,
    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_ISSUE = 2'd2,
        S_BAD   = 2'd3
    } state_t;

    state_t st;
    logic   s1, s2, s3;
    logic   load_rise;

    // Two flops to settle the raw button, a third for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= load;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign load_rise = s2 & ~s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st       <= S_A;
            A        <= '0;
            B        <= '0;
            select   <= '0;
            do_op    <= 1'b0;
            op_count <= 8'd0;
        end else begin
            do_op <= 1'b0;
            if (clear) begin
                st     <= S_A;
                A      <= '0;
                B      <= '0;
                select <= '0;
            end else begin
                case (st)
                    S_A: begin
                        if (load_rise) begin
                            A      <= data_in;
                            select <= sel_in;
                            if (sel_in == UNARY_OP) begin
                                B  <= '0;
                                st <= S_ISSUE;
                            end else begin
                                st <= S_B;
                            end
                        end
                    end
                    S_B: begin
                        if (load_rise) begin
                            B  <= data_in;
                            st <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        // Any press landing here is intentionally dropped
                        do_op    <= 1'b1;
                        op_count <= op_count + 8'd1;
                        st       <= S_A;
                    end
                    default: st <= S_A;
                endcase
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: vector table, scoreboard on do_op,
// and directed sequences for clear, reset and counter wrap.
module tb_alu_operand_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic [3:0] sel_in;
    logic       load;
    logic       clear;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] select;
    logic       do_op;
    logic [1:0] state;
    logic [7:0] op_count;

    always #5 clk = ~clk;

    alu_operand_loader dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .sel_in   (sel_in),
        .load     (load),
        .clear    (clear),
        .A        (A),
        .B        (B),
        .select   (select),
        .do_op    (do_op),
        .state    (state),
        .op_count (op_count)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] exp_b;
        logic       unary;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    int         n_checks = 0;
    int         n_fail   = 0;
    int         seen_do  = 0;
    logic [7:0] exp_count = 8'd0;
    logic       prev_do  = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every do pulse must match the oldest pending operation
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            exp_count = 8'd0;
            seen_do   = 0;
        end else if (do_op) begin
            check("do_gap", {31'd0, prev_do}, 32'd0);
            seen_do++;
            exp_count = exp_count + 8'd1;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_do: got do=1 expected none");
            end else begin
                e = sb.pop_front();
                check("sb_A", {24'd0, A}, {24'd0, e.a});
                check("sb_B", {24'd0, B}, {24'd0, e.b});
                check("sb_sel", {28'd0, select}, {28'd0, e.sel});
                check("sb_count", {24'd0, op_count}, {24'd0, exp_count});
            end
        end
        prev_do = do_op;
    end

    task automatic press(input logic [7:0] d, input logic [3:0] s);
        data_in = d;
        sel_in  = s;
        load    = 1'b1;
        repeat (3) @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_A"}, {24'd0, A}, 32'd0);
        check({tag, "_B"}, {24'd0, B}, 32'd0);
        check({tag, "_sel"}, {28'd0, select}, 32'd0);
        check({tag, "_state"}, {30'd0, state}, 32'd0);
        check({tag, "_do"}, {31'd0, do_op}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'h05, 8'h03, 4'h1, 8'h03, 1'b0};
        vecs[1] = '{8'h05, 8'hEE, 4'hC, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'h00, 4'h7, 8'h00, 1'b0};
        vecs[3] = '{8'h80, 8'h7F, 4'hF, 8'h7F, 1'b0};
        vecs[4] = '{8'h00, 8'h12, 4'hC, 8'h00, 1'b1};
        vecs[5] = '{8'hA5, 8'h5A, 4'h0, 8'h5A, 1'b0};
        vecs[6] = '{8'h3C, 8'hFF, 4'hB, 8'hFF, 1'b0};
        vecs[7] = '{8'hFF, 8'h01, 4'hC, 8'h00, 1'b1};

        reset   = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
        data_in = 8'h00;
        sel_in  = 4'h0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        check("rst_count", {24'd0, op_count}, 32'd0);
        #2 reset = 1'b1;
        @(negedge clk);

        // Basic binary operation
        press(8'h05, 4'h1);
        check("s1_A", {24'd0, A}, 32'h05);
        check("s1_sel", {28'd0, select}, 32'h1);
        check("s1_state", {30'd0, state}, 32'd1);
        check("s1_do", {31'd0, do_op}, 32'd0);
        sb.push_back('{a: 8'h05, b: 8'h03, sel: 4'h1});
        press(8'h03, 4'h0);
        check("s1_state2", {30'd0, state}, 32'd0);
        check("s1_count", {24'd0, op_count}, 32'd1);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{a: vecs[i].a, b: vecs[i].exp_b, sel: vecs[i].sel});
            press(vecs[i].a, vecs[i].sel);
            if (!vecs[i].unary) press(vecs[i].b, 4'h0);
            repeat (2) @(negedge clk);
            check("vec_holdA", {24'd0, A}, {24'd0, vecs[i].a});
            check("vec_holdB", {24'd0, B}, {24'd0, vecs[i].exp_b});
            check("vec_state", {30'd0, state}, 32'd0);
        end

        // Held button: one capture only
        data_in = 8'h9A;
        sel_in  = 4'h5;
        load    = 1'b1;
        repeat (50) @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        check("held_state", {30'd0, state}, 32'd1);
        check("held_A", {24'd0, A}, 32'h9A);
        sb.push_back('{a: 8'h9A, b: 8'h21, sel: 4'h5});
        press(8'h21, 4'h0);

        // Sub-cycle glitch between edges is never sampled
        data_in = 8'h44;
        sel_in  = 4'h1;
        @(negedge clk);
        #1 load = 1'b1;
        #2 load = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch_state", {30'd0, state}, 32'd0);

        // One-cycle press: at most one capture, never an issue
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        check("short_noissue", {31'd0, state[1]}, 32'd0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_zero("clr0");

        // Clear coinciding with the B capture edge
        press(8'h7F, 4'h2);
        check("c_pre_A", {24'd0, A}, 32'h7F);
        data_in = 8'h55;
        load    = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        load  = 1'b0;
        check_zero("clr1");
        repeat (4) @(negedge clk);
        check("clr_consumed", {30'd0, state}, 32'd0);
        press(8'h11, 4'h3);
        check("clr_nextA", {24'd0, A}, 32'h11);
        check("clr_nextB", {24'd0, B}, 32'h00);
        check("clr_next_st", {30'd0, state}, 32'd1);
        sb.push_back('{a: 8'h11, b: 8'h22, sel: 4'h3});
        press(8'h22, 4'h0);

        // Clear during issue suppresses the strobe
        press(8'h44, 4'h1);
        data_in = 8'h66;
        load    = 1'b1;
        repeat (3) @(negedge clk);
        load  = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_zero("clr2");
        repeat (3) @(negedge clk);
        check("clr2_count", {24'd0, op_count}, {24'd0, exp_count});

        // Asynchronous reset in the middle of an operation
        press(8'h05, 4'h1);
        check("ar_pre", {30'd0, state}, 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_zero("ar");
        check("ar_count", {24'd0, op_count}, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        press(8'h05, 4'h1);
        sb.push_back('{a: 8'h05, b: 8'h03, sel: 4'h1});
        press(8'h03, 4'h0);
        check("ar_post_count", {24'd0, op_count}, 32'd1);

        // Counter wrap over 256 unary operations
        do_reset();
        for (int i = 0; i < 256; i++) begin
            sb.push_back('{a: 8'(i), b: 8'h00, sel: 4'hC});
            press(8'(i), 4'hC);
        end
        repeat (3) @(negedge clk);
        check("wrap_count", {24'd0, op_count}, 32'd0);
        check("wrap_dos", seen_do, 32'd256);
        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Upstream operand/opcode sequencer for the 8-bit ALU datapath; feeds the ALU's A, B, select and do inputs.
- Captures operands from a shared 8-bit data bus on successive operator load presses, then issues a single-cycle do strobe.
- Unary opcodes (negate, 4'b1100) skip the B capture.
- Holds all outputs stable between operations so the ALU result register sees constant operands.

Parameters:
WIDTH, 8, operand width for data_in, A and B
SEL_W, 4, opcode width
UNARY_OP, 4'b1100, opcode that needs only A (two's-complement negate)

Ports:
clk  input  1  system clock, all flops rising-edge
reset  input  1  asynchronous active-low reset; 0 = reset asserted
data_in  input  WIDTH  operand value from switches
sel_in  input  SEL_W  opcode from switches
load  input  1  raw asynchronous load button, level
clear  input  1  synchronous abort/clear, active-high
A  output  WIDTH  registered operand A to ALU
B  output  WIDTH  registered operand B to ALU
select  output  SEL_W  registered opcode to ALU
do  output  1  registered one-cycle issue strobe
state  output  2  current FSM state (debug/LED)
op_count  output  8  number of do strobes issued, wraps 255 -> 0

Behaviour:
- Reset (reset=0, asynchronous): A=0, B=0, select=0, do=0, op_count=0, state=S_A, synchronizer flops=0. Release is synchronous to clk.
- Load conditioning:
  - 2-flop synchronizer, then rising-edge detect against a third flop: edge = s2 & ~s3.
  - With load high at clk edge k, edge is asserted during cycle k+2 and the capture happens at edge k+2.
  - Exactly one capture per press. A press held any length produces one edge; a press of <2 cycles may be missed.
- FSM states (state encoding): S_A=2'd0, S_B=2'd1, S_ISSUE=2'd2. 2'd3 is unused and recovers to S_A.
- S_A: on edge, A<=data_in and select<=sel_in.
  - If sel_in==UNARY_OP, B<=0 and go to S_ISSUE.
  - Otherwise go to S_B.
  - B is otherwise unchanged.
- S_B: on edge, B<=data_in, go to S_ISSUE. select and A are not re-sampled.
- S_ISSUE: stays exactly one cycle.
  - do=1 on the cycle after entry (do is registered, high for exactly one clk).
  - op_count increments by 1 mod 256.
  - Go to S_A.
  - An edge arriving during S_ISSUE is dropped.
- Between operations, A, B and select hold their last values until the next capture; the ALU result persists.
- do is never asserted outside the S_ISSUE->S_A transition; there are never two do pulses without a full capture sequence in between.
- clear=1 at a clk edge:
  - Sets state=S_A, A=0, B=0, select=0, do=0.
  - Takes priority over a simultaneous edge; that edge is consumed, not deferred.
  - op_count is not cleared.
  - clear during S_ISSUE suppresses the pending do.
- Reset mid-operation: everything returns to the reset values immediately, and a partially loaded operation is discarded.
- No arithmetic on operands: the block transports data only, at full WIDTH with no sign handling.

Test Plan:
1. Reset, then press load with data_in=8'h05, sel_in=4'b0001 -> A=05, select=0001, state=S_B, do=0. Press load with data_in=8'h03 -> B=03. Exactly one do pulse 1 cycle later; op_count=1; state=S_A.
2. Unary: press with data_in=8'h05, sel_in=4'b1100 -> A=05, B=00, select=1100, do pulses once without a second press, so the ALU yields 8'hFB. op_count increments.
3. Held button: load high for 50 cycles -> one capture only. A 1-cycle load pulse aligned between edges may produce zero captures, and never two.
4. Clear in S_B: after A=8'h7F, assert clear together with an edge -> A=B=select=0, state=S_A, no do. A following press captures into A, not B.
5. Async reset mid-S_B: drop reset between clk edges -> outputs zero immediately without a clock. After release, the sequence from scenario 1 works normally.
6. Counter wrap: issue 256 unary operations -> op_count returns to 0, with one do per operation and do never held high for 2 consecutive cycles.
